// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC register and IF/ID pipeline
// register.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall             hold PC and IF/ID (redirects and flush are ignored)
//   flush             load a bubble into IF/ID
//   PCSrc/adderResult branch taken / branch target
//   jump/jaddress     j or jal / jump target
//   jr/jrTarget       jr / register target
//   imem_addr         instruction-memory word address (equals PC)
//   imem_data         instruction word, combinational read of imem_addr
//   instruction_ID    registered instruction presented to decode
//   PCPlus1_ID        registered PC+1 of that instruction
//   valid_ID          1 when instruction_ID is a real fetched instruction
//
// Optional build macro FETCH_PERF_CNT_EN adds the saturating 16-bit
// performance counters fetch_count and stall_count.
module fetch_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              PCSrc,
  input  logic [9:0]        adderResult,
  input  logic              jump,
  input  logic [9:0]        jaddress,
  input  logic              jr,
  input  logic [9:0]        jrTarget,
  output logic [9:0]        imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instruction_ID,
  output logic [9:0]        PCPlus1_ID,
  output logic              valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int PC_W = 10;

  // PC+1 wraps from 1023 to 0; the carry out is dropped on purpose.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [PC_W-1:0]   pc_p0;
  logic [PC_W-1:0]   pc_plus1_p0;
  logic [PC_W-1:0]   pc_nxt_p0;
  logic              redirect_p0;
  logic              bubble_p0;

  logic [DATA_W-1:0] instr_p1;
  logic [PC_W-1:0]   pc_plus1_p1;
  logic              vld_p1;

  // ---- Stage p0: PC and next-PC selection ----
  assign imem_addr   = pc_p0;
  assign pc_plus1_p0 = pc_inc(pc_p0);
  assign redirect_p0 = !stall && (jr || jump || PCSrc);
  // The wrong-path word fetched alongside a redirect is squashed here.
  assign bubble_p0   = redirect_p0 || flush;

  always_comb begin
    pc_nxt_p0 = pc_plus1_p0;
    if (stall)      pc_nxt_p0 = pc_p0;
    else if (jr)    pc_nxt_p0 = jrTarget;
    else if (jump)  pc_nxt_p0 = jaddress;
    else if (PCSrc) pc_nxt_p0 = adderResult;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= '0;
    end else begin
      pc_p0 <= pc_nxt_p0;
    end
  end

  // ---- Stage p1: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1    <= '0;
      pc_plus1_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (!stall) begin
      if (bubble_p0) begin
        instr_p1    <= '0;
        pc_plus1_p1 <= '0;
        vld_p1      <= 1'b0;
      end else begin
        instr_p1    <= imem_data;
        pc_plus1_p1 <= pc_plus1_p0;
        vld_p1      <= 1'b1;
      end
    end
  end

  assign instruction_ID = instr_p1;
  assign PCPlus1_ID     = pc_plus1_p1;
  assign valid_ID       = vld_p1;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!stall && !bubble_p0) fetch_cnt_q <= sat_inc16(fetch_cnt_q);
      if (stall)                stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, PCSrc, jump, jr;
  logic [9:0]  adderResult, jaddress, jrTarget;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instruction_ID;
  logic [9:0]  PCPlus1_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds the value k.
  assign imem_data = {22'd0, imem_addr};

  fetch_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .PCSrc(PCSrc), .adderResult(adderResult),
    .jump(jump), .jaddress(jaddress),
    .jr(jr), .jrTarget(jrTarget),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction_ID(instruction_ID), .PCPlus1_ID(PCPlus1_ID),
    .valid_ID(valid_ID)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare PC and the full IF/ID contents in one call.
  task automatic expect_state(input string tag, input int pc, input int instr,
                              input int pcp1, input logic vld);
    check({tag, ".pc"},    32'(imem_addr),      32'(pc));
    check({tag, ".instr"}, instruction_ID,      32'(instr));
    check({tag, ".pcp1"},  32'(PCPlus1_ID),     32'(pcp1));
    check({tag, ".valid"}, 32'(valid_ID),       32'(vld));
  endtask

  task automatic clear_ctrl();
    stall = 0; flush = 0; PCSrc = 0; jump = 0; jr = 0;
    adderResult = '0; jaddress = '0; jrTarget = '0;
  endtask

  initial begin
    clear_ctrl();
    rst = 1;
    #2;
    expect_state("reset", 0, 0, 0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("reset.fetch_count", 32'(fetch_count), 0);
    check("reset.stall_count", 32'(stall_count), 0);
`endif
    #6 rst = 0;   // release between edges (t=8)

    // Sequential fetch after reset release.
    step(); expect_state("seq1", 1, 0, 1, 1'b1);
    step(); expect_state("seq2", 2, 1, 2, 1'b1);
    step(); expect_state("seq3", 3, 2, 3, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("seq.fetch_count", 32'(fetch_count), 3);
    check("seq.stall_count", 32'(stall_count), 0);
`endif
    step(); step(); expect_state("at5", 5, 4, 5, 1'b1);

    // Branch from PC=5 to 40.
    PCSrc = 1; adderResult = 10'd40;
    step(); expect_state("br.bubble", 40, 0, 0, 1'b0);
    clear_ctrl();
    step(); expect_state("br.target", 41, 40, 41, 1'b1);

    // jr, jump and branch together: jr wins, single bubble.
    jr = 1; jrTarget = 10'd7; jump = 1; jaddress = 10'd9; PCSrc = 1; adderResult = 10'd3;
    step(); expect_state("prio.bubble", 7, 0, 0, 1'b0);
    clear_ctrl();
    step(); expect_state("prio.target", 8, 7, 8, 1'b1);
    step(); expect_state("prio.next", 9, 8, 9, 1'b1);

    // Stall for 3 cycles with a pending branch: nothing moves.
    stall = 1; PCSrc = 1; adderResult = 10'd100;
    for (int i = 0; i < 3; i++) begin
      step(); expect_state($sformatf("stall%0d", i), 9, 8, 9, 1'b1);
    end
    stall = 0;
    step(); expect_state("stall.release", 100, 0, 0, 1'b0);
    clear_ctrl();
    step(); expect_state("stall.target", 101, 100, 101, 1'b1);

    // Flush without redirect: bubble, PC advances sequentially.
    flush = 1;
    step(); expect_state("flush", 102, 0, 0, 1'b0);
    clear_ctrl();
    step(); expect_state("flush.after", 103, 102, 103, 1'b1);

    // Flush under stall is ignored.
    stall = 1; flush = 1;
    step(); expect_state("stallflush", 103, 102, 103, 1'b1);
    clear_ctrl();

    // jump beats branch; then run across the 1023 -> 0 wrap.
    jump = 1; jaddress = 10'd1020; PCSrc = 1; adderResult = 10'd3;
    step(); expect_state("jump.bubble", 1020, 0, 0, 1'b0);
    clear_ctrl();
    step(); expect_state("jump.target", 1021, 1020, 1021, 1'b1);
    step(); step(); expect_state("at1023", 1023, 1022, 1023, 1'b1);
    step(); expect_state("wrap", 0, 1023, 0, 1'b1);

    // Walk to PC=12, then pulse reset between edges.
    repeat (12) step();
    expect_state("at12", 12, 11, 12, 1'b1);
    stall = 1; PCSrc = 1; adderResult = 10'd77;
    #2 rst = 1;
    #2 expect_state("async_rst", 0, 0, 0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("async_rst.fetch_count", 32'(fetch_count), 0);
    check("async_rst.stall_count", 32'(stall_count), 0);
`endif
    #1 rst = 0;
    clear_ctrl();
    step(); expect_state("post_rst", 1, 0, 1, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    // Stall counter saturation.
    stall = 1;
    repeat (70000) step();
    check("stall_count.sat", 32'(stall_count), 32'hFFFF);
    check("fetch_count.held", 32'(fetch_count), 1);
    clear_ctrl();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
